// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with bubble collapse and flush.
// Optional REG_PIPE_OCC_EN adds the registered Occ occupancy count port.
module reg_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Flush,
    output logic [WIDTH-1:0] Q,
    output logic             Out_Valid,
    input  logic             Out_Ready
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] Occ
`endif
);

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            w_rdy;
    logic [DEPTH-1:0]            w_leave;
    logic [DEPTH-1:0]            w_load;
    logic [DEPTH-1:0]            w_keep;
    logic [DEPTH-1:0][WIDTH-1:0] w_din;
    logic                        w_in_xfer;
    logic                        w_out_xfer;

    // w_rdy[k]: stage k can take a word this cycle (empty, or its word moves on)
    assign w_rdy[DEPTH-1]   = !r_vld[DEPTH-1] || Out_Ready;
    assign w_leave[DEPTH-1] = r_vld[DEPTH-1] && Out_Ready;

    assign w_out_xfer = r_vld[DEPTH-1] && Out_Ready;
    assign In_Ready   = w_rdy[0] && !Flush && !Reset;
    assign w_in_xfer  = In_Valid && In_Ready;

    assign w_load[0] = w_in_xfer;
    assign w_din[0]  = D;

    genvar k;
    generate
        for (k = 0; k < DEPTH - 1; k++) begin : g_chain
            assign w_rdy[k]     = !r_vld[k] || w_rdy[k+1];
            assign w_leave[k]   = r_vld[k] && w_rdy[k+1];
            assign w_load[k+1]  = w_leave[k];
            assign w_din[k+1]   = r_data[k];
        end

        for (k = 0; k < DEPTH; k++) begin : g_stage
            assign w_keep[k] = r_vld[k] && !w_leave[k];

            // Data only moves on a load; flushed or empty stages keep stale data
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_vld[k]  <= 1'b0;
                    r_data[k] <= '0;
                end else begin
                    r_vld[k] <= !Flush && (w_load[k] || w_keep[k]);
                    if (w_load[k] && !Flush)
                        r_data[k] <= w_din[k];
                end
            end
        end
    endgenerate

    assign Q         = r_data[DEPTH-1];
    assign Out_Valid = r_vld[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH+1);
    logic [OW-1:0] r_occ;

    always_ff @(posedge Clk) begin
        if (Reset || Flush)
            r_occ <= '0;
        else
            r_occ <= r_occ + OW'(w_in_xfer) - OW'(w_out_xfer);
    end

    assign Occ = r_occ;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: directed scenarios plus random traffic
// against a queue-of-words reference model.
module tb_reg_pipe;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             Clk = 1'b0;
    logic             Reset, In_Valid, Flush, Out_Ready;
    logic [WIDTH-1:0] D;
    logic             In_Ready, Out_Valid;
    logic [WIDTH-1:0] Q;
`ifdef REG_PIPE_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] Occ;
`endif

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .D(D), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Flush(Flush), .Q(Q), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
`ifdef REG_PIPE_OCC_EN
        , .Occ(Occ)
`endif
    );

    always #5 Clk = ~Clk;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: queue of words, oldest first, each with its stage position
    typedef struct { logic [WIDTH-1:0] d; int p; } ent_t;
    ent_t             mq[$];
    logic [WIDTH-1:0] m_q = '0;
    int               m_np[DEPTH+1];

    // Position each word reaches at the next edge; returns whether input is accepted
    function automatic bit m_calc(input bit ordy, input bit fl, input bit rs);
        int lim = DEPTH;
        for (int i = 0; i < mq.size(); i++) begin
            int np;
            if (i == 0 && mq[i].p == DEPTH-1)
                np = ordy ? DEPTH : DEPTH-1;
            else
                np = (mq[i].p + 1 < lim) ? mq[i].p + 1 : lim - 1;
            m_np[i] = np;
            lim = np;
        end
        return !(fl || rs) && (lim > 0);
    endfunction

    function automatic void m_update(input bit ir);
        if (Reset) begin
            mq.delete();
            m_q = '0;
        end else if (Flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (m_np[i] == DEPTH-1 && mq[i].p != DEPTH-1)
                    m_q = mq[i].d;
                mq[i].p = m_np[i];
            end
            if (mq.size() > 0 && mq[0].p == DEPTH)
                void'(mq.pop_front());
            if (In_Valid && ir)
                mq.push_back('{d: D, p: 0});
        end
    endfunction

    function automatic bit m_ov();
        return mq.size() > 0 && mq[0].p == DEPTH-1;
    endfunction

    typedef struct { int c; logic [WIDTH-1:0] d; } obs_t;
    obs_t oq[$];
    logic s_ir, s_ov;
    logic [WIDTH-1:0] s_q;

    // One clock cycle: inputs already driven; check at negedge, advance model at posedge
    task automatic step();
        bit ir;
        @(negedge Clk);
        ir = m_calc(Out_Ready, Flush, Reset);
        s_ir = In_Ready; s_ov = Out_Valid; s_q = Q;
        chk("in_ready", In_Ready, ir);
        chk("out_valid", Out_Valid, m_ov());
        chk("q", Q, m_q);
`ifdef REG_PIPE_OCC_EN
        chk("occ", Occ, mq.size());
`endif
        if (Out_Valid && Out_Ready)
            oq.push_back('{c: cyc, d: Q});
        @(posedge Clk);
        m_update(ir);
        cyc++;
        #1;
    endtask

    logic [WIDTH-1:0] exp4[4];
    logic [WIDTH-1:0] exp5[5];

    initial begin
        int c0;
        Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; D = '0;
        repeat (2) @(posedge Clk);
        #1;
        step();                          // reset state, In_Ready low during reset
        chk("rst_ir", s_ir, 0);
        chk("rst_q", s_q, 0);

        // Latency and ordered stream
        Reset = 1'b0; Out_Ready = 1'b1; In_Valid = 1'b1; oq.delete();
        exp4 = '{4'b0001, 4'b0010, 4'b0011, 4'b1100};
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            D = exp4[i];
            step();
            chk("r030_acc", s_ir, 1);
        end
        In_Valid = 1'b0;
        repeat (6) step();
        chk("r030_n", oq.size(), 4);
        for (int i = 0; i < 4 && i < oq.size(); i++) begin
            chk("r030_d", oq[i].d, exp4[i]);
            chk("r030_lat", oq[i].c - c0, 4 + i);
        end

        // Backpressure: fill, stall, then drain
        Out_Ready = 1'b0; In_Valid = 1'b1; oq.delete();
        exp5 = '{4'b1101, 4'b1110, 4'b1111, 4'b0000, 4'b0101};
        for (int i = 0; i < 4; i++) begin
            D = exp5[i];
            step();
            chk("r031_acc", s_ir, 1);
        end
        D = exp5[4];
        step();
        chk("r031_full", s_ir, 0);
`ifdef REG_PIPE_OCC_EN
        chk("r031_occ", Occ, 4);
`endif
        step();
        chk("r031_stall_q", s_q, 4'b1101);
        Out_Ready = 1'b1;
        step();
        chk("r031_take", s_ir, 1);
        In_Valid = 1'b0;
        repeat (6) step();
        chk("r031_n", oq.size(), 5);
        for (int i = 0; i < 5 && i < oq.size(); i++)
            chk("r031_d", oq[i].d, exp5[i]);

        // Full with Out_Ready: simultaneous in and out
        Out_Ready = 1'b0; In_Valid = 1'b1; oq.delete();
        for (int i = 0; i < 4; i++) begin
            D = 4'($urandom_range(0, 9));
            step();
        end
        Out_Ready = 1'b1; D = 4'b1010;
        step();
        chk("r032_ir", s_ir, 1);
        chk("r032_ov", s_ov, 1);
`ifdef REG_PIPE_OCC_EN
        chk("r032_occ", Occ, 4);
`endif
        In_Valid = 1'b0;
        repeat (6) step();
        chk("r032_n", oq.size(), 5);
        if (oq.size() > 0) chk("r032_last", oq[oq.size()-1].d, 4'b1010);

        // Flush with two words in flight and an offered word
        In_Valid = 1'b1;
        D = 4'b1001; step();
        D = 4'b0110; step();
        oq.delete();
        Flush = 1'b1; D = 4'b0111;
        step();
        chk("r033_ir", s_ir, 0);
        Flush = 1'b0; In_Valid = 1'b0;
        step();
        chk("r033_ov", s_ov, 0);
        chk("r033_q", s_q, 4'b1010);
`ifdef REG_PIPE_OCC_EN
        chk("r033_occ", Occ, 0);
`endif
        repeat (6) step();
        chk("r033_none", oq.size(), 0);

        // Reset mid-stream
        In_Valid = 1'b1;
        D = 4'b0011; step();
        D = 4'b0101; step();
        D = 4'b0110; step();
        oq.delete();
        Reset = 1'b1; D = 4'b1111;
        step();
        chk("r034_ir", s_ir, 0);
        Reset = 1'b0; In_Valid = 1'b0;
        step();
        chk("r034_q", s_q, 0);
        chk("r034_ov", s_ov, 0);
        chk("r034_ir_after", s_ir, 1);
`ifdef REG_PIPE_OCC_EN
        chk("r034_occ", Occ, 0);
`endif
        repeat (8) step();
        chk("r034_none", oq.size(), 0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            In_Valid  = ($urandom_range(0, 99) < 70);
            Out_Ready = ($urandom_range(0, 99) < 60);
            Flush     = ($urandom_range(0, 99) < 3);
            Reset     = ($urandom_range(0, 199) < 1);
            D         = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port D, input, WIDTH, the input data word.
REQ-006 The block SHALL have port In_Valid, input, 1, meaning D holds a word to transfer.
REQ-007 The block SHALL have port In_Ready, output, 1, meaning the block accepts D this cycle.
REQ-008 The block SHALL have port Flush, input, 1, a synchronous discard of all held words.
REQ-009 The block SHALL have port Q, output, WIDTH, the data of the last stage.
REQ-010 The block SHALL have port Out_Valid, output, 1, meaning Q holds a valid word.
REQ-011 The block SHALL have port Out_Ready, input, 1, meaning the consumer takes Q this cycle.
REQ-012 The block SHALL have port Occ, output, clog2(DEPTH+1), giving the count of valid stages (present only per REQ-029).

Function
REQ-013 The block SHALL use DEPTH stages (0..DEPTH-1), each holding a WIDTH data register and a valid bit; Q/Out_Valid SHALL be the data and valid of stage DEPTH-1.
REQ-014 An input transfer SHALL occur in any cycle with In_Valid=1 and In_Ready=1, and D SHALL be loaded into stage 0 at that rising edge.
REQ-015 An output transfer SHALL occur in any cycle with Out_Valid=1 and Out_Ready=1.
REQ-016 Stage k SHALL advance to stage k+1 when stage k+1 is empty or stage k+1 itself advances, and the last stage SHALL advance on an output transfer; empty stages SHALL collapse in the same cycle.
REQ-017 In_Ready SHALL be combinational: 1 when stage 0 is empty or stage 0 advances, and 0 whenever Flush=1 or Reset=1.
REQ-018 Latency: with Out_Ready held 1 and the pipe empty, a word transferred in cycle c SHALL appear on Q with Out_Valid=1 in cycle c+DEPTH.
REQ-019 Throughput SHALL be one word per cycle sustained, including when full with Out_Ready=1, in which case In_Ready=1 and input and output transfer in the same cycle.
REQ-020 When full (all stages valid) and Out_Ready=0, In_Ready SHALL be 0, and no stage SHALL change.
REQ-021 While Out_Valid=1 and Out_Ready=0, Q SHALL remain stable.
REQ-022 A stage data register SHALL only be written when that stage loads; an empty stage SHALL retain its old data.
REQ-023 Word order SHALL be preserved, with no loss or duplication.
REQ-024 Flush=1 SHALL clear every valid bit at the rising edge, discard any input offered that cycle, and leave data registers unchanged.
REQ-025 An output transfer in a Flush cycle SHALL still count as consumed.

Reset
REQ-026 Reset=1 at a rising edge SHALL clear all valid bits and all data registers to 0, giving Q=0, Out_Valid=0 and Occ=0; Reset SHALL take priority over Flush and any transfer.
REQ-027 During a Reset cycle, In_Ready SHALL be 0; in the first cycle after Reset deasserts, In_Ready SHALL be 1.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight words with no partial output afterwards.

Configuration
REQ-029 With macro REG_PIPE_OCC_EN defined, port Occ SHALL exist and equal the number of valid stages (0..DEPTH), registered and updated at the same edge as the valid bits; without it, Occ and its counter logic SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=4, DEPTH=4)
REQ-030 Bench SHALL verify: Reset, then D=4'b0001,0010,0011,1100 offered on successive cycles with Out_Ready=1 -> Q shows 0001 with Out_Valid=1 four cycles after the first transfer, then 0010,0011,1100 on consecutive cycles.
REQ-031 Bench SHALL verify: Out_Ready=0 while offering 1101,1110,1111,0000,0101 -> first four accepted, In_Ready=0 on the fifth, Occ=4; raising Out_Ready drains 1101..0000 in order, then accepts 0101.
REQ-032 Bench SHALL verify: full pipe, Out_Ready=1, In_Valid=1 with D=1010 -> In_Ready=1, one word out and 1010 in at the same edge, Occ stays 4.
REQ-033 Bench SHALL verify: two words in flight, Flush=1 with In_Valid=1 and D=0111 -> next cycle Out_Valid=0, Occ=0, 0111 never emerges, and Q retains its previous value.
REQ-034 Bench SHALL verify: Reset=1 asserted with three words in flight and In_Valid=1 -> next cycle Q=0, Out_Valid=0, Occ=0, In_Ready was 0 during the Reset cycle, and no stale word appears later.
REQ-035 Bench SHALL verify: a build without REG_PIPE_OCC_EN repeating REQ-030 and REQ-031 -> identical Q/Out_Valid/In_Ready traces.
